// File: rtl/ga_vd_buff_rd_arb.sv
`default_nettype none
// ============================================================================
//  Module   : ga_vd_buff_rd_arb
//  Brief    : Round-robin arbiter sharing the V,d buffer read port among
//             N_REQ fitness lanes, with a fixed-latency read-valid return.
//  Revision : 1.0  initial release
// ============================================================================
module ga_vd_buff_rd_arb #(
    parameter int N_REQ  = 4,
    parameter int IDX_W  = 8,
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     sw_rst,
    input  logic                     arb_enable,
    input  logic [IDX_W:0]           cnfg_depth,
    input  logic                     wr_busy,
    input  logic [N_REQ-1:0]         req_vec,
    input  logic [N_REQ*IDX_W-1:0]   req_idx_flat,
    output logic [N_REQ-1:0]         gnt_vec,
    output logic [N_REQ-1:0]         rvalid_vec,
    output logic                     buff_rd_req,
    output logic [IDX_W-1:0]         buff_rd_idx,
    output logic                     idx_err_pls,
    output logic                     busy
);

    localparam int                 C_PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [C_PTR_W:0]   C_N_EXT = (C_PTR_W+1)'(N_REQ);
    localparam logic [C_PTR_W-1:0] C_LAST  = C_PTR_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                        state_q,   state_d;
    logic [C_PTR_W-1:0]            ptr_q,     ptr_d;
    logic [N_REQ-1:0]              gnt_q,     gnt_d;
    logic [RD_LAT-1:0][N_REQ-1:0]  pipe_q,    pipe_d;
    logic                          rd_req_q,  rd_req_d;
    logic [IDX_W-1:0]              rd_idx_q,  rd_idx_d;
    logic                          idx_err_q, idx_err_d;

    logic [N_REQ-1:0]              w_elig;
    logic [C_PTR_W:0]              w_lane;
    logic                          w_win_found;
    logic [C_PTR_W-1:0]            w_win_ptr;
    logic [N_REQ-1:0]              w_win_oh;
    logic [IDX_W-1:0]              w_win_idx;
    logic                          w_grant_ok;
    logic                          w_in_flight;

    // A lane whose grant is visible this cycle still shows its old request.
    assign w_elig = req_vec & ~gnt_q;

    always_comb begin
        w_win_found = 1'b0;
        w_win_ptr   = '0;
        w_lane      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_lane = {1'b0, ptr_q} + (C_PTR_W+1)'(i);
            if (w_lane >= C_N_EXT) begin
                w_lane = w_lane - C_N_EXT;
            end
            if (!w_win_found && w_elig[w_lane[C_PTR_W-1:0]]) begin
                w_win_found = 1'b1;
                w_win_ptr   = w_lane[C_PTR_W-1:0];
            end
        end
    end

    always_comb begin
        w_win_oh  = '0;
        w_win_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_win_found && (w_win_ptr == C_PTR_W'(k))) begin
                w_win_oh[k] = 1'b1;
                w_win_idx   = req_idx_flat[k*IDX_W +: IDX_W];
            end
        end
    end

    assign w_grant_ok  = (state_q == ST_ARB) && arb_enable && !wr_busy && w_win_found;
    // The read is outstanding from its grant cycle through its rvalid cycle.
    assign w_in_flight = (|gnt_q) || (|pipe_q);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = '0;
        rd_req_d  = 1'b0;
        rd_idx_d  = rd_idx_q;
        idx_err_d = 1'b0;
        pipe_d    = '0;

        pipe_d[0] = gnt_q;
        for (int s = 1; s < RD_LAT; s++) begin
            pipe_d[s] = pipe_q[s-1];
        end

        case (state_q)
            ST_IDLE:  if (arb_enable)   state_d = ST_ARB;
            ST_ARB:   if (!arb_enable)  state_d = ST_DRAIN;
            ST_DRAIN: if (!w_in_flight) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase

        if (w_grant_ok) begin
            gnt_d     = w_win_oh;
            rd_req_d  = 1'b1;
            rd_idx_d  = w_win_idx;
            // Out-of-range reads are still issued; the flag is informational.
            idx_err_d = ({1'b0, w_win_idx} >= cnfg_depth);
            ptr_d     = (w_win_ptr == C_LAST) ? '0 : (w_win_ptr + C_PTR_W'(1));
        end

        if (sw_rst) begin
            state_d   = ST_IDLE;
            ptr_d     = '0;
            gnt_d     = '0;
            rd_req_d  = 1'b0;
            rd_idx_d  = '0;
            idx_err_d = 1'b0;
            pipe_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            pipe_q    <= '0;
            rd_req_q  <= 1'b0;
            rd_idx_q  <= '0;
            idx_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            pipe_q    <= pipe_d;
            rd_req_q  <= rd_req_d;
            rd_idx_q  <= rd_idx_d;
            idx_err_q <= idx_err_d;
        end
    end

    assign gnt_vec     = gnt_q;
    assign rvalid_vec  = pipe_q[RD_LAT-1];
    assign buff_rd_req = rd_req_q;
    assign buff_rd_idx = rd_idx_q;
    assign idx_err_pls = idx_err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ga_vd_buff_rd_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ga_vd_buff_rd_arb
//  Brief    : Directed vector table plus randomized run against a
//             grant-history reference model for ga_vd_buff_rd_arb.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ga_vd_buff_rd_arb;

    localparam int N   = 4;
    localparam int IW  = 8;
    localparam int LAT = 2;

    typedef logic [18:0] obs_t;   // {gnt, rvalid, rd_req, err, busy, idx}

    typedef struct {
        logic        en;
        logic        wb;
        logic        sw;
        logic [3:0]  rq;
        logic [31:0] ix;
        logic [3:0]  g;
        logic [3:0]  rv;
        logic        rd;
        logic        er;
        logic        bz;
        logic [7:0]  oi;
    } vec_t;

    logic              clk = 1'b0;
    logic              rstn;
    logic              sw_rst;
    logic              arb_enable;
    logic [IW:0]       cnfg_depth;
    logic              wr_busy;
    logic [N-1:0]      req_vec;
    logic [N*IW-1:0]   req_idx_flat;
    logic [N-1:0]      gnt_vec;
    logic [N-1:0]      rvalid_vec;
    logic              buff_rd_req;
    logic [IW-1:0]     buff_rd_idx;
    logic              idx_err_pls;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    vec_t tbl[$];

    // Reference model: mode 0 idle / 1 arbitrating / 2 draining, plus the
    // last LAT+1 cycles of grants (newest first, -1 = no grant).
    int          m_mode;
    int          m_ptr;
    int          m_hist[$];
    logic [7:0]  m_idx;
    logic        m_err;

    ga_vd_buff_rd_arb #(
        .N_REQ  (N),
        .IDX_W  (IW),
        .RD_LAT (LAT)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .sw_rst       (sw_rst),
        .arb_enable   (arb_enable),
        .cnfg_depth   (cnfg_depth),
        .wr_busy      (wr_busy),
        .req_vec      (req_vec),
        .req_idx_flat (req_idx_flat),
        .gnt_vec      (gnt_vec),
        .rvalid_vec   (rvalid_vec),
        .buff_rd_req  (buff_rd_req),
        .buff_rd_idx  (buff_rd_idx),
        .idx_err_pls  (idx_err_pls),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(logic [3:0] g, logic [3:0] rv, logic rd,
                                logic er, logic bz, logic [7:0] ix);
        return {g, rv, rd, er, bz, (rd ? ix : 8'h00)};
    endfunction

    function automatic void model_reset();
        m_mode = 0;
        m_ptr  = 0;
        m_hist.delete();
        for (int i = 0; i <= LAT; i++) m_hist.push_back(-1);
        m_idx  = 8'h00;
        m_err  = 1'b0;
    endfunction

    function automatic void model_step();
        bit inflight;
        int g;
        int l;
        if (!rstn || sw_rst) begin
            model_reset();
            return;
        end
        inflight = 1'b0;
        foreach (m_hist[i]) if (m_hist[i] >= 0) inflight = 1'b1;
        g     = -1;
        m_err = 1'b0;
        if (m_mode == 1 && arb_enable && !wr_busy) begin
            for (int i = 0; i < N; i++) begin
                l = (m_ptr + i) % N;
                if (g < 0 && (((req_vec >> l) & 4'd1) != 4'd0) && l != m_hist[0]) g = l;
            end
        end
        if (g >= 0) begin
            m_ptr = (g + 1) % N;
            m_idx = 8'(req_idx_flat >> (g * IW));
            m_err = ({1'b0, m_idx} >= cnfg_depth);
        end
        case (m_mode)
            0:       if (arb_enable)  m_mode = 1;
            1:       if (!arb_enable) m_mode = 2;
            default: if (!inflight)   m_mode = 0;
        endcase
        m_hist.push_front(g);
        void'(m_hist.pop_back());
    endfunction

    function automatic obs_t model_exp();
        logic [3:0] g;
        logic [3:0] rv;
        g  = (m_hist[0]   >= 0) ? 4'(1 << m_hist[0])   : 4'd0;
        rv = (m_hist[LAT] >= 0) ? 4'(1 << m_hist[LAT]) : 4'd0;
        return mk(g, rv, (m_hist[0] >= 0), m_err, (m_mode != 0), m_idx);
    endfunction

    task automatic check(input string name, input obs_t exp);
        obs_t act;
        act = mk(gnt_vec, rvalid_vec, buff_rd_req, idx_err_pls, busy, buff_rd_idx);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t: got gnt=%b rv=%b rd=%b err=%b busy=%b idx=%0d; want gnt=%b rv=%b rd=%b err=%b busy=%b idx=%0d",
                     name, $time, act[18:15], act[14:11], act[10], act[9], act[8], act[7:0],
                     exp[18:15], exp[14:11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic void add_row(logic en, logic wb, logic sw, logic [3:0] rq,
                                    logic [31:0] ix, logic [3:0] g, logic [3:0] rv,
                                    logic rd, logic er, logic bz, logic [7:0] oi);
        vec_t r;
        r.en = en; r.wb = wb; r.sw = sw; r.rq = rq; r.ix = ix;
        r.g  = g;  r.rv = rv; r.rd = rd; r.er = er; r.bz = bz; r.oi = oi;
        tbl.push_back(r);
    endfunction

    initial begin
        logic [31:0] ia, ib, ic;
        ia = 32'h09070503;   // lanes 0..3 -> 3,5,7,9
        ib = 32'h09100503;   // lane 2 -> 16
        ic = 32'h090F0503;   // lane 2 -> 15

        rstn = 1'b0; sw_rst = 1'b0; arb_enable = 1'b0; wr_busy = 1'b0;
        cnfg_depth = 9'd16; req_vec = '0; req_idx_flat = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset", '0);
        rstn = 1'b1;

        //       en wb sw req      idx  gnt      rvalid   rd er bz idx
        add_row(1, 0, 0, 4'b0000, ia, 4'b0000, 4'b0000, 0, 0, 1, 0);
        add_row(1, 0, 0, 4'b1111, ia, 4'b0001, 4'b0000, 1, 0, 1, 3);
        add_row(1, 0, 0, 4'b1111, ia, 4'b0010, 4'b0000, 1, 0, 1, 5);
        add_row(1, 0, 0, 4'b1111, ia, 4'b0100, 4'b0001, 1, 0, 1, 7);
        add_row(1, 0, 0, 4'b1111, ia, 4'b1000, 4'b0010, 1, 0, 1, 9);
        add_row(1, 0, 0, 4'b1111, ia, 4'b0001, 4'b0100, 1, 0, 1, 3);
        add_row(1, 0, 0, 4'b0100, ia, 4'b0100, 4'b1000, 1, 0, 1, 7);
        add_row(1, 0, 0, 4'b1001, ia, 4'b1000, 4'b0001, 1, 0, 1, 9);
        add_row(1, 0, 0, 4'b1001, ia, 4'b0001, 4'b0100, 1, 0, 1, 3);
        add_row(1, 1, 0, 4'b0010, ia, 4'b0000, 4'b1000, 0, 0, 1, 0);
        add_row(1, 1, 0, 4'b0010, ia, 4'b0000, 4'b0001, 0, 0, 1, 0);
        add_row(1, 0, 0, 4'b0010, ia, 4'b0010, 4'b0000, 1, 0, 1, 5);
        add_row(1, 0, 0, 4'b0100, ib, 4'b0100, 4'b0000, 1, 1, 1, 16);
        add_row(1, 0, 0, 4'b0100, ic, 4'b0000, 4'b0010, 0, 0, 1, 0);
        add_row(1, 0, 0, 4'b0100, ic, 4'b0100, 4'b0100, 1, 0, 1, 15);
        add_row(0, 0, 0, 4'b0000, ia, 4'b0000, 4'b0000, 0, 0, 1, 0);
        add_row(0, 0, 0, 4'b1111, ia, 4'b0000, 4'b0100, 0, 0, 1, 0);
        add_row(0, 0, 0, 4'b1111, ia, 4'b0000, 4'b0000, 0, 0, 1, 0);
        add_row(0, 0, 0, 4'b1111, ia, 4'b0000, 4'b0000, 0, 0, 0, 0);
        add_row(1, 0, 0, 4'b0000, ia, 4'b0000, 4'b0000, 0, 0, 1, 0);
        add_row(1, 0, 0, 4'b0001, ia, 4'b0001, 4'b0000, 1, 0, 1, 3);
        add_row(1, 0, 1, 4'b0000, ia, 4'b0000, 4'b0000, 0, 0, 0, 0);
        add_row(0, 0, 0, 4'b0000, ia, 4'b0000, 4'b0000, 0, 0, 0, 0);
        add_row(0, 0, 0, 4'b0000, ia, 4'b0000, 4'b0000, 0, 0, 0, 0);
        add_row(1, 0, 0, 4'b0000, ia, 4'b0000, 4'b0000, 0, 0, 1, 0);
        add_row(1, 0, 0, 4'b1111, ia, 4'b0001, 4'b0000, 1, 0, 1, 3);

        foreach (tbl[i]) begin
            arb_enable   = tbl[i].en;
            wr_busy      = tbl[i].wb;
            sw_rst       = tbl[i].sw;
            req_vec      = tbl[i].rq;
            req_idx_flat = tbl[i].ix;
            tick();
            check($sformatf("vec%0d", i),
                  mk(tbl[i].g, tbl[i].rv, tbl[i].rd, tbl[i].er, tbl[i].bz, tbl[i].oi));
        end

        arb_enable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                #2;
                rstn = 1'b0;
                #1;
                check("async_rst", '0);
                model_reset();
                for (int j = 0; j < 2; j++) begin
                    tick();
                    check("rst_hold", model_exp());
                end
                #2;
                rstn = 1'b1;
            end
            if ($urandom_range(0, 39) == 0) arb_enable = ~arb_enable;
            wr_busy = ($urandom_range(0, 3) == 0);
            sw_rst  = ($urandom_range(0, 149) == 0);
            req_vec = 4'($urandom_range(0, 15));
            for (int k = 0; k < N; k++) req_idx_flat[k*IW +: IW] = 8'($urandom_range(0, 31));
            if ($urandom_range(0, 199) == 0) cnfg_depth = 9'($urandom_range(1, 32));
            tick();
            check("rand", model_exp());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ga_vd_buff_rd_arb.md
GA_VD_BUFF_RD_ARB -- requirements
Module: ga_vd_buff_rd_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of read requesters (fitness lanes) sharing the V,d buffer read port.
REQ-002 Parameter IDX_W, default 8, read index width (equals B_IDX_MAX_W).
REQ-003 Parameter RD_LAT, default 1, buffer read latency in cycles from rd_req to valid o_data.
REQ-004 clk  input  1  single clock, all logic on posedge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 sw_rst  input  1  synchronous soft reset, same effect as rstn.
REQ-007 arb_enable  input  1  arbitration enable (ga_enable qualified).
REQ-008 cnfg_depth  input  IDX_W+1  configured buffer depth (cnfg_b).
REQ-009 wr_busy  input  1  buffer write this cycle (add_elem); blocks read.
REQ-010 req_vec  input  N_REQ  per-requester read request level.
REQ-011 req_idx_flat  input  N_REQ*IDX_W  per-requester index, lane k at [k*IDX_W +: IDX_W].
REQ-012 gnt_vec  output  N_REQ  one-hot grant, registered.
REQ-013 rvalid_vec  output  N_REQ  one-hot data-valid, RD_LAT cycles after the grant.
REQ-014 buff_rd_req  output  1  read request to buffer.
REQ-015 buff_rd_idx  output  IDX_W  read index to buffer.
REQ-016 idx_err_pls  output  1  one-cycle pulse: granted index >= cnfg_depth.
REQ-017 busy  output  1  high in ARB or DRAIN state.

Function
REQ-018 FSM states IDLE, ARB, DRAIN; IDLE->ARB when arb_enable=1; ARB->DRAIN when arb_enable=0; DRAIN->IDLE when no read in flight; DRAIN->ARB never directly.
REQ-019 In ARB, each cycle with wr_busy=0 and any req_vec bit set: grant exactly one lane, round-robin from priority pointer ptr.
REQ-020 Grant registered: gnt_vec, buff_rd_req=1, buff_rd_idx=req_idx of winner, all in the cycle after arbitration.
REQ-021 After granting lane k, ptr <= (k+1) mod N_REQ; wrap from N_REQ-1 to 0.
REQ-022 No grant (ptr unchanged) when wr_busy=1, no requests, or state != ARB; gnt_vec=0 and buff_rd_req=0 that cycle.
REQ-023 Requester holds req and idx stable until its gnt bit seen; it deasserts or presents next idx the cycle after gnt.
REQ-024 Lane granted at cycle t is ineligible at t+1 (req sampled same cycle as gnt still high); eligible again from t+2.
REQ-025 rvalid_vec = gnt_vec delayed RD_LAT cycles via shift pipeline; at most one bit set.
REQ-026 In-flight count = number of set stages in the rvalid pipeline plus current grant; DRAIN exits only when zero.
REQ-027 idx_err_pls asserted with the grant when winner idx >= cnfg_depth; read still issued (buffer defines data).
REQ-028 Single lane (N_REQ=1) grants every other cycle per REQ-024.
REQ-029 arb_enable falling while grant registered: that read completes and rvalid asserts; no new grants.

Reset
REQ-030 rstn=0 or sw_rst=1: state IDLE, ptr=0, gnt_vec=0, rvalid_vec and pipeline=0, buff_rd_req=0, buff_rd_idx=0, idx_err_pls=0, busy=0.
REQ-031 Reset mid-read discards in-flight reads; no rvalid after reset release.

Verification
REQ-032 All four req high, idx 3,5,7,9, no wr_busy -> grants lanes 0,1,2,3,0... one per cycle, buff_rd_idx 3,5,7,9; rvalid follows by RD_LAT.
REQ-033 ptr=3, req_vec=4'b1001 -> grant lane 3 then lane 0 (wrap), ptr becomes 1.
REQ-034 wr_busy=1 for 2 cycles with req_vec=4'b0010 -> no grant those cycles, lane 1 granted cycle after wr_busy falls.
REQ-035 cnfg_depth=16, lane 2 idx 16 -> grant issued, idx_err_pls=1 one cycle; idx 15 -> no pulse.
REQ-036 arb_enable drops one cycle after a grant, RD_LAT=2 -> state DRAIN, rvalid delivered, busy drops, state IDLE, no further grants.
REQ-037 sw_rst pulse with grant in flight -> all outputs 0 next cycle, no rvalid, ptr=0.
